// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: alarm FSM encoding and the
// layout of the 32-bit BCD display word produced by the timekeeper.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } ring_state_t;

   localparam int HOUR_LSB = 24;
   localparam int MIN_LSB  = 12;
   localparam int SEC_LSB  = 0;

   localparam logic [3:0] SEP_NIBBLE = 4'ha;

   function automatic logic [7:0] bcd_field(input logic [31:0] word, input int lsb);
      return word[lsb +: 8];
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Buzzer tone source: square wave at the tone frequency, gated by a
// 0.5 s on / 0.5 s off beep envelope that restarts on every clear.
module tone_gen #(
   parameter int HALF      = 5,
   parameter int BEEP_HALF = 500
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tone
);

   localparam int TONE_W = $clog2(HALF) + 1;
   localparam int BEEP_W = $clog2(BEEP_HALF) + 1;
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(HALF - 1);
   localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

   logic [TONE_W-1:0] tone_cnt;
   logic [BEEP_W-1:0] beep_cnt;
   logic              tone_q;
   logic              beep_on;

   // Clear wins over enable so the envelope always starts "on" with the tone low.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
         beep_cnt <= '0;
         beep_on  <= 1'b1;
      end else if (clr) begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
         beep_cnt <= '0;
         beep_on  <= 1'b1;
      end else if (en) begin
         if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
         end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
         end
         if (beep_cnt == BEEP_LAST) begin
            beep_cnt <= '0;
            beep_on  <= ~beep_on;
         end else begin
            beep_cnt <= beep_cnt + BEEP_W'(1);
         end
      end
   end

   assign tone = tone_q & beep_on;

endmodule

// File: rtl/alarm_ring.sv
// Alarm trigger and buzzer controller: detects the alarm minute, rings with
// auto-off, and supports snooze and stop keys.
module alarm_ring
   import clock_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TONE_HZ    = 2000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic [31:0] disp_time,
   input  logic [31:0] disp_alarm,
   input  logic        alarm_indicator,
   input  logic        sec_tick,
   input  logic        stop_pulse,
   input  logic        snooze_pulse,
   output logic        buzzer,
   output logic        ringing,
   output logic        snoozed
);

   localparam int HALF      = CLK_HZ / (2 * TONE_HZ);
   localparam int BEEP_HALF = CLK_HZ / 2;
   localparam int SNZ_SEC   = SNOOZE_MIN * 60;
   localparam int RING_W    = $clog2(RING_SEC) + 1;
   localparam int SNZ_W     = $clog2(SNZ_SEC) + 1;

   localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);
   localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
   localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNZ_SEC);
   localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

   ring_state_t       state;
   logic [RING_W-1:0] ring_cnt;
   logic [SNZ_W-1:0]  snz_cnt;
   logic              match;
   logic              match_d;
   logic              trigger;
   logic              tone;
   logic              unused_sep;

   assign match = alarm_indicator
                & (bcd_field(disp_time, HOUR_LSB) == bcd_field(disp_alarm, HOUR_LSB))
                & (bcd_field(disp_time, MIN_LSB)  == bcd_field(disp_alarm, MIN_LSB))
                & (bcd_field(disp_time, SEC_LSB)  == 8'h00);

   assign trigger = match & ~match_d;

   // Separator nibbles and the alarm seconds byte carry no information here.
   assign unused_sep = ^{disp_time[23:20] ^ SEP_NIBBLE, disp_time[11:8] ^ SEP_NIBBLE,
                         disp_alarm[23:20] ^ SEP_NIBBLE, disp_alarm[11:0]};

   tone_gen #(
      .HALF      (HALF),
      .BEEP_HALF (BEEP_HALF)
   ) u_tone_gen (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .clr     (state != ST_RING),
      .en      (state == ST_RING),
      .tone    (tone)
   );

   // Every exit from RING forces buzzer low on the same edge as ringing falls.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         match_d  <= 1'b0;
         ringing  <= 1'b0;
         snoozed  <= 1'b0;
         buzzer   <= 1'b0;
      end else begin
         match_d <= match;
         buzzer  <= (state == ST_RING) & tone;
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  state    <= ST_RING;
                  ring_cnt <= RING_LOAD;
                  ringing  <= 1'b1;
               end
            end
            ST_RING: begin
               if (!alarm_indicator || stop_pulse) begin
                  state   <= ST_IDLE;
                  ringing <= 1'b0;
                  buzzer  <= 1'b0;
               end else if (snooze_pulse) begin
                  state   <= ST_SNOOZE;
                  snz_cnt <= SNZ_LOAD;
                  ringing <= 1'b0;
                  snoozed <= 1'b1;
                  buzzer  <= 1'b0;
               end else if (sec_tick) begin
                  if (ring_cnt == RING_ONE) begin
                     state   <= ST_IDLE;
                     ringing <= 1'b0;
                     buzzer  <= 1'b0;
                  end
                  ring_cnt <= ring_cnt - RING_W'(1);
               end
            end
            ST_SNOOZE: begin
               if (!alarm_indicator || stop_pulse) begin
                  state   <= ST_IDLE;
                  snoozed <= 1'b0;
               end else if (sec_tick) begin
                  if (snz_cnt == SNZ_ONE) begin
                     state    <= ST_RING;
                     ring_cnt <= RING_LOAD;
                     ringing  <= 1'b1;
                     snoozed  <= 1'b0;
                  end
                  snz_cnt <= snz_cnt - SNZ_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               ringing <= 1'b0;
               snoozed <= 1'b0;
               buzzer  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring with a 1 kHz clock, 100 Hz tone, 3 s ring
// and 1 min snooze so every scenario runs in a few thousand cycles.
module tb_alarm_ring;
   import clock_pkg::*;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [31:0] disp_time;
   logic [31:0] disp_alarm;
   logic        alarm_indicator;
   logic        sec_tick;
   logic        stop_pulse;
   logic        snooze_pulse;
   logic        buzzer;
   logic        ringing;
   logic        snoozed;

   int checks   = 0;
   int failures = 0;

   alarm_ring #(
      .CLK_HZ     (1000),
      .TONE_HZ    (100),
      .RING_SEC   (3),
      .SNOOZE_MIN (1)
   ) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .disp_time       (disp_time),
      .disp_alarm      (disp_alarm),
      .alarm_indicator (alarm_indicator),
      .sec_tick        (sec_tick),
      .stop_pulse      (stop_pulse),
      .snooze_pulse    (snooze_pulse),
      .buzzer          (buzzer),
      .ringing         (ringing),
      .snoozed         (snoozed)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] tword(input logic [7:0] h, input logic [7:0] m,
                                         input logic [7:0] s);
      return {h, SEP_NIBBLE, m, SEP_NIBBLE, s};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic tick();
      sec_tick = 1'b1;
      step(1);
      sec_tick = 1'b0;
      step(1);
   endtask

   task automatic retrigger();
      disp_time = tword(8'h07, 8'h29, 8'h59);
      step(2);
      disp_time = tword(8'h07, 8'h30, 8'h00);
      step(1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ringing"}, {31'd0, ringing}, 32'd0);
      check({tag, "_snoozed"}, {31'd0, snoozed}, 32'd0);
      check({tag, "_buzzer"},  {31'd0, buzzer},  32'd0);
   endtask

   initial begin
      int   first_buzz;
      int   bad;
      logic exp_b;

      rst_n           = 1'b0;
      disp_alarm      = tword(8'h07, 8'h30, 8'h00);
      disp_time       = tword(8'h07, 8'h29, 8'h59);
      alarm_indicator = 1'b1;
      sec_tick        = 1'b0;
      stop_pulse      = 1'b0;
      snooze_pulse    = 1'b0;

      step(2);
      check_idle("reset");
      rst_n = 1'b1;
      step(3);
      check("pre_match_ringing", {31'd0, ringing}, 32'd0);

      disp_time = tword(8'h07, 8'h30, 8'h00);
      step(1);
      check("trigger_ringing", {31'd0, ringing}, 32'd1);
      check("trigger_buzzer", {31'd0, buzzer}, 32'd0);

      // Edge k after entry: buzzer reflects tone ((k-1)/5 odd) and envelope ((k-1)/500 even).
      first_buzz = 0;
      bad        = 0;
      for (int k = 1; k <= 1010; k++) begin
         step(1);
         exp_b = ((((k - 1) / 5) % 2) == 1) && ((((k - 1) / 500) % 2) == 0);
         if (buzzer !== exp_b) bad++;
         if (buzzer === 1'b1 && first_buzz == 0) first_buzz = k;
      end
      check("first_buzz_delay", first_buzz, 6);
      check("beep_pattern_errors", bad, 0);

      tick();
      tick();
      check("autooff_two_ticks", {31'd0, ringing}, 32'd1);
      tick();
      check("autooff_ringing", {31'd0, ringing}, 32'd0);
      check("autooff_buzzer", {31'd0, buzzer}, 32'd0);
      step(20);
      check("no_retrigger_sec00", {31'd0, ringing}, 32'd0);

      retrigger();
      check("snz_retrigger", {31'd0, ringing}, 32'd1);
      step(3);
      snooze_pulse = 1'b1;
      step(1);
      snooze_pulse = 1'b0;
      check("snz_snoozed", {31'd0, snoozed}, 32'd1);
      check("snz_ringing", {31'd0, ringing}, 32'd0);
      check("snz_buzzer", {31'd0, buzzer}, 32'd0);
      snooze_pulse = 1'b1;
      step(1);
      snooze_pulse = 1'b0;
      for (int i = 0; i < 59; i++) tick();
      check("snz_59_ticks", {31'd0, snoozed}, 32'd1);
      tick();
      check("snz_expire_ringing", {31'd0, ringing}, 32'd1);
      check("snz_expire_snoozed", {31'd0, snoozed}, 32'd0);
      step(10);
      stop_pulse = 1'b1;
      step(1);
      stop_pulse = 1'b0;
      check_idle("snz_stop");

      retrigger();
      check("both_retrigger", {31'd0, ringing}, 32'd1);
      stop_pulse   = 1'b1;
      snooze_pulse = 1'b1;
      step(1);
      stop_pulse   = 1'b0;
      snooze_pulse = 1'b0;
      check_idle("both_keys");

      retrigger();
      snooze_pulse = 1'b1;
      step(1);
      snooze_pulse = 1'b0;
      check("ind_snoozed", {31'd0, snoozed}, 32'd1);
      alarm_indicator = 1'b0;
      step(1);
      check_idle("ind_drop");

      disp_alarm = tword(8'h23, 8'h59, 8'h00);
      disp_time  = tword(8'h23, 8'h58, 8'h59);
      step(2);
      disp_time = tword(8'h23, 8'h59, 8'h00);
      step(3);
      check("disarmed_no_ring", {31'd0, ringing}, 32'd0);

      alarm_indicator = 1'b1;
      disp_alarm      = tword(8'h07, 8'h30, 8'h00);
      disp_time       = tword(8'h07, 8'h29, 8'h59);
      step(2);
      disp_time = tword(8'h07, 8'h30, 8'h00);
      sec_tick  = 1'b1;
      step(1);
      sec_tick = 1'b0;
      check("entry_tick_ringing", {31'd0, ringing}, 32'd1);
      tick();
      tick();
      check("entry_tick_not_counted", {31'd0, ringing}, 32'd1);
      tick();
      check("entry_tick_autooff", {31'd0, ringing}, 32'd0);

      retrigger();
      step(6);
      check("pre_reset_buzzer", {31'd0, buzzer}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      rst_n = 1'b1;
      step(1);
      check("post_reset_trigger", {31'd0, ringing}, 32'd1);
      stop_pulse = 1'b1;
      step(1);
      stop_pulse = 1'b0;
      check_idle("final_stop");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
